// File: rtl/alu_share_arb_pkg.sv
// Shared definitions for the two-requester ALU share: opcodes, flag bit positions
// and the registered response record.
package alu_pkg;

  localparam int ALU_W   = 32;
  localparam int FLAGS_W = 4;

  localparam int FLAG_Z = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_op_e;

  typedef struct packed {
    logic [ALU_W-1:0]   result;
    logic [FLAGS_W-1:0] flags;
    logic               err;
  } alu_rsp_t;

  function automatic logic is_legal_op(input logic [2:0] ctrl);
    case (ctrl)
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT: return 1'b1;
      default:                                    return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_share_arb_if.sv
// One requester's channel: valid/ready request carrying an ALU op, and a
// valid/ready response carrying the registered result, flags and error bit.
interface alu_share_arb_if #(
  parameter int DATA_W = 32
);
  import alu_pkg::*;

  logic                rq_valid;
  logic                rq_ready;
  logic [DATA_W-1:0]   rq_a;
  logic [DATA_W-1:0]   rq_b;
  logic [2:0]          rq_ctrl;
  logic                rs_valid;
  logic                rs_ready;
  logic [DATA_W-1:0]   rs_result;
  logic [FLAGS_W-1:0]  rs_flags;
  logic                rs_err;

  modport master (
    output rq_valid, rq_a, rq_b, rq_ctrl, rs_ready,
    input  rq_ready, rs_valid, rs_result, rs_flags, rs_err
  );

  modport slave (
    input  rq_valid, rq_a, rq_b, rq_ctrl, rs_ready,
    output rq_ready, rs_valid, rs_result, rs_flags, rs_err
  );

endinterface

// File: rtl/alu_share_arb_alu.sv
// Combinational 32-bit ALU: add, sub, and, or, signed set-less-than.
// Flags are {zero, carry, negative, overflow}; carry on sub means "no borrow".
module alu
  import alu_pkg::*;
(
  input  logic [ALU_W-1:0]   i_a,
  input  logic [ALU_W-1:0]   i_b,
  input  logic [2:0]         i_ctrl,
  output logic [ALU_W-1:0]   o_result,
  output logic [FLAGS_W-1:0] o_flags
);

  logic             w_sub;
  logic [ALU_W-1:0] w_b_eff;
  logic [ALU_W:0]   w_sum;
  logic             w_ovf;
  logic             w_carry;
  logic             w_vflag;

  // Sub and slt share the adder as a + ~b + 1.
  assign w_sub   = (i_ctrl == ALU_SUB) || (i_ctrl == ALU_SLT);
  assign w_b_eff = w_sub ? ~i_b : i_b;
  assign w_sum   = {1'b0, i_a} + {1'b0, w_b_eff} + {{ALU_W{1'b0}}, w_sub};
  assign w_ovf   = (i_a[ALU_W-1] == w_b_eff[ALU_W-1]) && (w_sum[ALU_W-1] != i_a[ALU_W-1]);

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // a value unassigned, which would otherwise infer a latch.
    o_result = '0;
    w_carry  = 1'b0;
    w_vflag  = 1'b0;
    case (i_ctrl)
      ALU_ADD, ALU_SUB: begin
        o_result = w_sum[ALU_W-1:0];
        w_carry  = w_sum[ALU_W];
        w_vflag  = w_ovf;
      end
      ALU_AND: o_result = i_a & i_b;
      ALU_OR:  o_result = i_a | i_b;
      ALU_SLT: o_result = {{(ALU_W-1){1'b0}}, w_sum[ALU_W-1] ^ w_ovf};
      default: o_result = '0;
    endcase
  end

  always_comb begin
    o_flags         = '0;
    o_flags[FLAG_Z] = (o_result == '0);
    o_flags[FLAG_C] = w_carry;
    o_flags[FLAG_N] = o_result[ALU_W-1];
    o_flags[FLAG_V] = w_vflag;
  end

endmodule

// File: rtl/alu_share_arb_rr_arb2.sv
// Two-way arbiter with a one-bit round-robin pointer; the pointer names the
// requester that wins when both are eligible.
module alu_rr_arb2 #(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_eligible,
  output logic [1:0] o_grant
);

  logic       r_ptr;
  logic [1:0] w_grant;

  always_comb begin
    w_grant = 2'b00;
    case (i_eligible)
      2'b01:   w_grant = 2'b01;
      2'b10:   w_grant = 2'b10;
      2'b11:   w_grant = (FIXED_PRIO || !r_ptr) ? 2'b01 : 2'b10;
      default: w_grant = 2'b00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state is updated with non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    if (!rst_n) begin
      r_ptr <= 1'b0;
    end else if (|w_grant) begin
      // Point at the requester that did not win this cycle.
      r_ptr <= w_grant[0];
    end
  end

  assign o_grant = w_grant;

endmodule

// File: rtl/alu_share_arb.sv
// Shares one ALU between two requesters: arbitrates, issues one op per cycle and
// registers each result into that requester's response slot (1-cycle latency).
module alu_share_arb
  import alu_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic            clk,
  input  logic            rst_n,
  alu_share_arb_if.slave  p0_if,
  alu_share_arb_if.slave  p1_if
);

  logic [1:0]        w_rq_valid;
  logic [1:0]        w_rs_ready;
  logic [1:0]        w_eligible;
  logic [1:0]        w_grant;
  logic [DATA_W-1:0] w_rq_a [2];
  logic [DATA_W-1:0] w_rq_b [2];
  logic [2:0]        w_rq_ctrl [2];

  logic [DATA_W-1:0]  w_alu_a;
  logic [DATA_W-1:0]  w_alu_b;
  logic [2:0]         w_alu_ctrl;
  logic [ALU_W-1:0]   w_alu_result;
  logic [FLAGS_W-1:0] w_alu_flags;
  alu_rsp_t           w_rsp_next;

  logic [1:0] r_rs_valid;
  alu_rsp_t   r_rsp [2];

  assign w_rq_valid   = {p1_if.rq_valid, p0_if.rq_valid};
  assign w_rs_ready   = {p1_if.rs_ready, p0_if.rs_ready};
  assign w_rq_a[0]    = p0_if.rq_a;
  assign w_rq_a[1]    = p1_if.rq_a;
  assign w_rq_b[0]    = p0_if.rq_b;
  assign w_rq_b[1]    = p1_if.rq_b;
  assign w_rq_ctrl[0] = p0_if.rq_ctrl;
  assign w_rq_ctrl[1] = p1_if.rq_ctrl;

  // A slot can take a new result if it is empty or being drained this cycle.
  assign w_eligible = w_rq_valid & (~r_rs_valid | w_rs_ready);

  alu_rr_arb2 #(
    .FIXED_PRIO (FIXED_PRIO)
  ) u_arb (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_eligible (w_eligible),
    .o_grant    (w_grant)
  );

  assign w_alu_a    = w_grant[1] ? w_rq_a[1]    : w_rq_a[0];
  assign w_alu_b    = w_grant[1] ? w_rq_b[1]    : w_rq_b[0];
  assign w_alu_ctrl = w_grant[1] ? w_rq_ctrl[1] : w_rq_ctrl[0];

  alu u_alu (
    .i_a      (w_alu_a),
    .i_b      (w_alu_b),
    .i_ctrl   (w_alu_ctrl),
    .o_result (w_alu_result),
    .o_flags  (w_alu_flags)
  );

  always_comb begin
    w_rsp_next        = '0;
    if (is_legal_op(w_alu_ctrl)) begin
      w_rsp_next.result = w_alu_result;
      w_rsp_next.flags  = w_alu_flags;
    end else begin
      w_rsp_next.flags[FLAG_Z] = 1'b1;
      w_rsp_next.err           = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the two response slots are plain registers, not a RAM, so they
    // take the async reset like any other state.
    if (!rst_n) begin
      r_rs_valid <= 2'b00;
      for (int n = 0; n < 2; n++) r_rsp[n] <= '0;
    end else begin
      for (int n = 0; n < 2; n++) begin
        if (w_grant[n]) begin
          r_rs_valid[n] <= 1'b1;
          r_rsp[n]      <= w_rsp_next;
        end else if (w_rs_ready[n]) begin
          r_rs_valid[n] <= 1'b0;
        end
      end
    end
  end

  assign p0_if.rq_ready  = w_grant[0];
  assign p0_if.rs_valid  = r_rs_valid[0];
  assign p0_if.rs_result = r_rsp[0].result;
  assign p0_if.rs_flags  = r_rsp[0].flags;
  assign p0_if.rs_err    = r_rsp[0].err;

  assign p1_if.rq_ready  = w_grant[1];
  assign p1_if.rs_valid  = r_rs_valid[1];
  assign p1_if.rs_result = r_rsp[1].result;
  assign p1_if.rs_flags  = r_rsp[1].flags;
  assign p1_if.rs_err    = r_rsp[1].err;

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed bench for alu_share_arb: reset, round-robin, backpressure,
// consume+accept, overflow/illegal ops and async reset mid-stream.
module tb_alu_share_arb;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  alu_share_arb_if #(.DATA_W(32)) rq0_if ();
  alu_share_arb_if #(.DATA_W(32)) rq1_if ();

  alu_share_arb #(
    .DATA_W     (32),
    .FIXED_PRIO (1'b0)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .p0_if (rq0_if.slave),
    .p1_if (rq1_if.slave)
  );

  task automatic drive(input int n, input logic v, input logic [31:0] a,
                       input logic [31:0] b, input logic [2:0] c);
    if (n == 0) begin
      rq0_if.rq_valid = v; rq0_if.rq_a = a; rq0_if.rq_b = b; rq0_if.rq_ctrl = c;
    end else begin
      rq1_if.rq_valid = v; rq1_if.rq_a = a; rq1_if.rq_b = b; rq1_if.rq_ctrl = c;
    end
  endtask

  task automatic set_rs_ready(input logic r0, input logic r1);
    rq0_if.rs_ready = r0;
    rq1_if.rs_ready = r1;
  endtask

  task automatic idle();
    @(negedge clk);
    drive(0, 1'b0, 32'd0, 32'd0, 3'b000);
    drive(1, 1'b0, 32'd0, 32'd0, 3'b000);
    set_rs_ready(1'b1, 1'b1);
    @(posedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive(0, 1'b0, 32'd0, 32'd0, 3'b000);
    drive(1, 1'b0, 32'd0, 32'd0, 3'b000);
    set_rs_ready(1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    drive(0, 1'b0, 32'd0, 32'd0, 3'b000);
    drive(1, 1'b0, 32'd0, 32'd0, 3'b000);
    set_rs_ready(1'b0, 1'b0);
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++; if (rq0_if.rs_valid !== 1'b0 || rq1_if.rs_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b%b expected 00", rq1_if.rs_valid, rq0_if.rs_valid); end
    n_tests++; if (rq0_if.rs_result !== 32'd0 || rq0_if.rs_flags !== 4'd0 || rq0_if.rs_err !== 1'b0) begin n_fail++; $display("FAIL reset_rs0: got %h/%b/%b expected 0/0000/0", rq0_if.rs_result, rq0_if.rs_flags, rq0_if.rs_err); end
    n_tests++; if (rq1_if.rs_result !== 32'd0 || rq1_if.rs_flags !== 4'd0 || rq1_if.rs_err !== 1'b0) begin n_fail++; $display("FAIL reset_rs1: got %h/%b/%b expected 0/0000/0", rq1_if.rs_result, rq1_if.rs_flags, rq1_if.rs_err); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    @(negedge clk);
    drive(0, 1'b1, 32'd5, 32'd3, ALU_ADD);
    set_rs_ready(1'b1, 1'b1);
    #1;
    n_tests++; if (rq0_if.rq_ready !== 1'b1 || rq1_if.rq_ready !== 1'b0) begin n_fail++; $display("FAIL basic_ready: got %b%b expected 01", rq1_if.rq_ready, rq0_if.rq_ready); end
    @(posedge clk); #1;
    n_tests++; if (rq0_if.rs_valid !== 1'b1 || rq0_if.rs_result !== 32'd8 || rq0_if.rs_flags !== 4'b0000 || rq0_if.rs_err !== 1'b0) begin n_fail++; $display("FAIL basic_rs0: got v=%b %h/%b/%b expected v=1 00000008/0000/0", rq0_if.rs_valid, rq0_if.rs_result, rq0_if.rs_flags, rq0_if.rs_err); end
    idle();
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_g;
    do_reset();
    drive(0, 1'b1, 32'd3, 32'd5, ALU_SUB);
    drive(1, 1'b1, 32'd10, 32'd4, ALU_AND);
    set_rs_ready(1'b1, 1'b1);
    for (int k = 0; k < 4; k++) begin
      exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
      #1;
      n_tests++; if ({rq1_if.rq_ready, rq0_if.rq_ready} !== exp_g) begin n_fail++; $display("FAIL rr_grant%0d: got %b expected %b", k, {rq1_if.rq_ready, rq0_if.rq_ready}, exp_g); end
      @(posedge clk); #1;
      if (exp_g == 2'b01) begin
        n_tests++; if (rq0_if.rs_valid !== 1'b1 || rq1_if.rs_valid !== 1'b0 || rq0_if.rs_result !== 32'hFFFF_FFFE || rq0_if.rs_flags !== 4'b0010) begin n_fail++; $display("FAIL rr_rs0_%0d: got v=%b%b %h/%b expected v=01 fffffffe/0010", k, rq1_if.rs_valid, rq0_if.rs_valid, rq0_if.rs_result, rq0_if.rs_flags); end
      end else begin
        n_tests++; if (rq1_if.rs_valid !== 1'b1 || rq0_if.rs_valid !== 1'b0 || rq1_if.rs_result !== 32'd0 || rq1_if.rs_flags !== 4'b1000) begin n_fail++; $display("FAIL rr_rs1_%0d: got v=%b%b %h/%b expected v=10 00000000/1000", k, rq1_if.rs_valid, rq0_if.rs_valid, rq1_if.rs_result, rq1_if.rs_flags); end
      end
      @(negedge clk);
    end
    idle();
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    drive(0, 1'b1, 32'h1234_5678, 32'h0F0F_0F0F, ALU_OR);
    drive(1, 1'b0, 32'd0, 32'd0, 3'b000);
    set_rs_ready(1'b0, 1'b1);
    @(posedge clk);
    @(negedge clk);
    drive(0, 1'b1, 32'd1, 32'd1, ALU_ADD);
    drive(1, 1'b1, 32'd9, 32'd4, ALU_SUB);
    for (int k = 0; k < 3; k++) begin
      #1;
      n_tests++; if (rq0_if.rq_ready !== 1'b0 || rq1_if.rq_ready !== 1'b1) begin n_fail++; $display("FAIL bp_grant%0d: got %b%b expected 10", k, rq1_if.rq_ready, rq0_if.rq_ready); end
      @(posedge clk); #1;
      n_tests++; if (rq0_if.rs_valid !== 1'b1 || rq0_if.rs_result !== 32'h1F3F_5F7F || rq0_if.rs_flags !== 4'b0000) begin n_fail++; $display("FAIL bp_rs0_hold%0d: got v=%b %h/%b expected v=1 1f3f5f7f/0000", k, rq0_if.rs_valid, rq0_if.rs_result, rq0_if.rs_flags); end
      n_tests++; if (rq1_if.rs_valid !== 1'b1 || rq1_if.rs_result !== 32'd5 || rq1_if.rs_flags !== 4'b0100) begin n_fail++; $display("FAIL bp_rs1_%0d: got v=%b %h/%b expected v=1 00000005/0100", k, rq1_if.rs_valid, rq1_if.rs_result, rq1_if.rs_flags); end
      @(negedge clk);
    end
    set_rs_ready(1'b1, 1'b1);
    #1;
    n_tests++; if ({rq1_if.rq_ready, rq0_if.rq_ready} !== 2'b01) begin n_fail++; $display("FAIL bp_release_grant: got %b expected 01", {rq1_if.rq_ready, rq0_if.rq_ready}); end
    @(posedge clk); #1;
    n_tests++; if (rq0_if.rs_valid !== 1'b1 || rq0_if.rs_result !== 32'd2) begin n_fail++; $display("FAIL bp_release_rs0: got v=%b %h expected v=1 00000002", rq0_if.rs_valid, rq0_if.rs_result); end
    idle();
  endtask

  task automatic test_consume_accept();
    @(negedge clk);
    drive(0, 1'b1, 32'd2, 32'd2, ALU_ADD);
    set_rs_ready(1'b0, 1'b1);
    @(posedge clk);
    @(negedge clk);
    drive(0, 1'b1, 32'd7, 32'd1, ALU_OR);
    set_rs_ready(1'b1, 1'b1);
    #1;
    n_tests++; if (rq0_if.rq_ready !== 1'b1) begin n_fail++; $display("FAIL ca_ready: got %b expected 1", rq0_if.rq_ready); end
    @(posedge clk); #1;
    n_tests++; if (rq0_if.rs_valid !== 1'b1 || rq0_if.rs_result !== 32'd7 || rq0_if.rs_flags !== 4'b0000) begin n_fail++; $display("FAIL ca_first: got v=%b %h/%b expected v=1 00000007/0000", rq0_if.rs_valid, rq0_if.rs_result, rq0_if.rs_flags); end
    @(negedge clk);
    drive(0, 1'b1, 32'd0, 32'd0, ALU_AND);
    @(posedge clk); #1;
    n_tests++; if (rq0_if.rs_valid !== 1'b1 || rq0_if.rs_result !== 32'd0 || rq0_if.rs_flags !== 4'b1000) begin n_fail++; $display("FAIL ca_second: got v=%b %h/%b expected v=1 00000000/1000", rq0_if.rs_valid, rq0_if.rs_result, rq0_if.rs_flags); end
    @(negedge clk);
    drive(0, 1'b0, 32'd0, 32'd0, 3'b000);
    @(posedge clk); #1;
    n_tests++; if (rq0_if.rs_valid !== 1'b0) begin n_fail++; $display("FAIL ca_drain: got v=%b expected 0", rq0_if.rs_valid); end
    idle();
  endtask

  task automatic test_overflow_illegal();
    @(negedge clk);
    set_rs_ready(1'b1, 1'b1);
    drive(0, 1'b1, 32'h7FFF_FFFF, 32'd1, ALU_ADD);
    @(posedge clk); #1;
    n_tests++; if (rq0_if.rs_result !== 32'h8000_0000 || rq0_if.rs_flags !== 4'b0011 || rq0_if.rs_err !== 1'b0) begin n_fail++; $display("FAIL add_ovf: got %h/%b/%b expected 80000000/0011/0", rq0_if.rs_result, rq0_if.rs_flags, rq0_if.rs_err); end
    @(negedge clk);
    drive(0, 1'b1, 32'h8000_0000, 32'd1, ALU_SUB);
    @(posedge clk); #1;
    n_tests++; if (rq0_if.rs_result !== 32'h7FFF_FFFF || rq0_if.rs_flags !== 4'b0101) begin n_fail++; $display("FAIL sub_ovf: got %h/%b expected 7fffffff/0101", rq0_if.rs_result, rq0_if.rs_flags); end
    @(negedge clk);
    drive(0, 1'b1, 32'hFFFF_FFFF, 32'd1, ALU_SLT);
    @(posedge clk); #1;
    n_tests++; if (rq0_if.rs_result !== 32'd1 || rq0_if.rs_err !== 1'b0) begin n_fail++; $display("FAIL slt_neg: got %h/%b expected 00000001/0", rq0_if.rs_result, rq0_if.rs_err); end
    @(negedge clk);
    drive(0, 1'b1, 32'd5, 32'd3, 3'b111);
    #1;
    n_tests++; if (rq0_if.rq_ready !== 1'b1) begin n_fail++; $display("FAIL illegal_ready: got %b expected 1", rq0_if.rq_ready); end
    @(posedge clk); #1;
    n_tests++; if (rq0_if.rs_valid !== 1'b1 || rq0_if.rs_result !== 32'd0 || rq0_if.rs_flags !== 4'b1000 || rq0_if.rs_err !== 1'b1) begin n_fail++; $display("FAIL illegal_111: got v=%b %h/%b/%b expected v=1 00000000/1000/1", rq0_if.rs_valid, rq0_if.rs_result, rq0_if.rs_flags, rq0_if.rs_err); end
    @(negedge clk);
    drive(0, 1'b0, 32'd0, 32'd0, 3'b000);
    drive(1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b100);
    @(posedge clk); #1;
    n_tests++; if (rq1_if.rs_valid !== 1'b1 || rq1_if.rs_result !== 32'd0 || rq1_if.rs_flags !== 4'b1000 || rq1_if.rs_err !== 1'b1) begin n_fail++; $display("FAIL illegal_100: got v=%b %h/%b/%b expected v=1 00000000/1000/1", rq1_if.rs_valid, rq1_if.rs_result, rq1_if.rs_flags, rq1_if.rs_err); end
    @(negedge clk);
    drive(1, 1'b1, 32'd6, 32'd6, ALU_SUB);
    @(posedge clk); #1;
    n_tests++; if (rq1_if.rs_err !== 1'b0 || rq1_if.rs_flags !== 4'b1100) begin n_fail++; $display("FAIL legal_after_illegal: got %b/%b expected 1100/0", rq1_if.rs_flags, rq1_if.rs_err); end
    idle();
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    set_rs_ready(1'b1, 1'b0);
    drive(1, 1'b1, 32'd20, 32'd22, ALU_ADD);
    @(posedge clk);
    @(negedge clk);
    drive(1, 1'b0, 32'd0, 32'd0, 3'b000);
    drive(0, 1'b1, 32'd1, 32'd1, ALU_ADD);
    @(posedge clk); #1;
    n_tests++; if (rq1_if.rs_valid !== 1'b1 || rq1_if.rs_result !== 32'd42) begin n_fail++; $display("FAIL ar_pre: got v=%b %h expected v=1 0000002a", rq1_if.rs_valid, rq1_if.rs_result); end
    drive(1, 1'b1, 32'd3, 32'd3, ALU_ADD);
    #1 rst_n = 1'b0;
    #1;
    n_tests++; if (rq1_if.rs_valid !== 1'b0 || rq1_if.rs_result !== 32'd0 || rq0_if.rs_valid !== 1'b0) begin n_fail++; $display("FAIL ar_clear: got v=%b%b rs1=%h expected v=00 rs1=00000000", rq1_if.rs_valid, rq0_if.rs_valid, rq1_if.rs_result); end
    @(negedge clk);
    rst_n = 1'b1;
    set_rs_ready(1'b1, 1'b1);
    #1;
    n_tests++; if ({rq1_if.rq_ready, rq0_if.rq_ready} !== 2'b01) begin n_fail++; $display("FAIL ar_ptr: got %b expected 01", {rq1_if.rq_ready, rq0_if.rq_ready}); end
    @(posedge clk); #1;
    n_tests++; if (rq0_if.rs_valid !== 1'b1 || rq0_if.rs_result !== 32'd2 || rq1_if.rs_valid !== 1'b0) begin n_fail++; $display("FAIL ar_after: got v=%b%b rs0=%h expected v=01 rs0=00000002", rq1_if.rs_valid, rq0_if.rs_valid, rq0_if.rs_result); end
    idle();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_round_robin();
    test_backpressure();
    test_consume_accept();
    test_overflow_illegal();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
